// File: rtl/conv_bram_sr_fast_ctrl.sv
// Control unit for the fast shift-register conv datapath.
// Streams image columns out of the row-banked BRAMs, one output row after
// another, and drives the datapath shift/sum strobes and result address.
module conv_bram_sr_fast_ctrl #(
  parameter int IMG_W    = 16,
  parameter int IMG_H    = 16,
  parameter int FILTER_L = 3,
  parameter int STRIDE_H = 1,
  localparam int RESULT_W              = IMG_W - FILTER_L + 1,
  localparam int RESULT_H              = (IMG_H - FILTER_L) / STRIDE_H + 1,
  localparam int BANK_ADDR_WIDTH       = $clog2(IMG_W * ((IMG_H + FILTER_L - 1) / FILTER_L)),
  localparam int FILTER_L_ADDR_WIDTH   = $clog2(FILTER_L),
  localparam int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W * RESULT_H)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic [FILTER_L*BANK_ADDR_WIDTH-1:0]   img_rdaddr,
  output logic                                  dpath_wren,
  output logic [FILTER_L_ADDR_WIDTH-1:0]        dpath_rotation_offset,
  output logic                                  dpath_sum_en,
  output logic [RESULT_RAM_ADDR_WIDTH-1:0]      dpath_result_wraddr,
  input  logic                                  last_val
);

  localparam int BA    = BANK_ADDR_WIDTH;
  localparam int FLW   = FILTER_L_ADDR_WIDTH;
  localparam int RRA   = RESULT_RAM_ADDR_WIDTH;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (RESULT_H > 1) ? $clog2(RESULT_H) : 1;

  // A step of STRIDE_H rows splits into whole bank-row blocks plus a residue
  // on the bank rotation; both are elaboration-time constants.
  localparam int             STEP_MOD   = STRIDE_H % FILTER_L;
  localparam logic [BA-1:0]  ROW_STRIDE = BA'(IMG_W);
  localparam logic [BA-1:0]  STEP_BLK   = BA'((STRIDE_H / FILTER_L) * IMG_W);

  typedef enum logic [2:0] {IDLE, STREAM, FLUSH, WAIT_LAST, DONE} state_t;

  state_t           state;
  logic [COL_W-1:0] w_cnt;
  logic [ROW_W-1:0] ho_cnt;
  logic [FLW-1:0]   h0_mod;
  logic [BA-1:0]    h0_blk;
  logic             flush_cnt;
  logic             last_seen;
  logic             win_s1;
  logic [RRA-1:0]   res_cnt;

  logic [FLW:0]     mod_sum;
  logic [FLW-1:0]   adv_mod;
  logic [BA-1:0]    adv_blk;
  logic             row_end;
  logic             last_read;
  logic [COL_W-1:0] rd_col;
  logic [FLW-1:0]   rd_mod;
  logic [BA-1:0]    rd_blk;
  logic [FILTER_L*BA-1:0] nxt_addr;

  // Advance the top output row by STRIDE_H: bump the rotation and carry whole blocks.
  always_comb begin
    mod_sum = {1'b0, h0_mod} + (FLW+1)'(STEP_MOD);
    adv_mod = h0_mod;
    adv_blk = h0_blk;
    if (mod_sum >= (FLW+1)'(FILTER_L)) begin
      adv_mod = FLW'(mod_sum - (FLW+1)'(FILTER_L));
      adv_blk = h0_blk + STEP_BLK + ROW_STRIDE;
    end else begin
      adv_mod = mod_sum[FLW-1:0];
      adv_blk = h0_blk + STEP_BLK;
    end
  end

  // Next read position; banks below the rotation point already hold the next block row.
  always_comb begin
    row_end   = (w_cnt == COL_W'(IMG_W - 1));
    last_read = row_end && (ho_cnt == ROW_W'(RESULT_H - 1));
    rd_col    = w_cnt + COL_W'(1);
    rd_mod    = h0_mod;
    rd_blk    = h0_blk;
    if (row_end) begin
      rd_col = '0;
      rd_mod = adv_mod;
      rd_blk = adv_blk;
    end
    nxt_addr = '0;
    for (int b = 0; b < FILTER_L; b++) begin
      nxt_addr[b*BA +: BA] = rd_blk + ((FLW'(b) < rd_mod) ? ROW_STRIDE : '0) + BA'(rd_col);
    end
  end

  // Main sequencer: start handshake, read issue, flush, wait for last_val, done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      img_rdaddr <= '0;
      w_cnt      <= '0;
      ho_cnt     <= '0;
      h0_mod     <= '0;
      h0_blk     <= '0;
      flush_cnt  <= 1'b0;
      last_seen  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= STREAM;
            busy       <= 1'b1;
            w_cnt      <= '0;
            ho_cnt     <= '0;
            h0_mod     <= '0;
            h0_blk     <= '0;
            img_rdaddr <= '0;
            last_seen  <= 1'b0;
          end
        end
        STREAM: begin
          if (last_read) begin
            state      <= FLUSH;
            flush_cnt  <= 1'b0;
            img_rdaddr <= '0;
          end else begin
            w_cnt      <= rd_col;
            img_rdaddr <= nxt_addr;
            if (row_end) begin
              ho_cnt <= ho_cnt + ROW_W'(1);
              h0_mod <= adv_mod;
              h0_blk <= adv_blk;
            end
          end
        end
        FLUSH: begin
          if (last_val) last_seen <= 1'b1;
          flush_cnt <= 1'b1;
          if (flush_cnt) state <= WAIT_LAST;
        end
        WAIT_LAST: begin
          if (last_val || last_seen) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath strobes trail the read by one (shift) and two (window valid) cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dpath_wren            <= 1'b0;
      dpath_rotation_offset <= '0;
      win_s1                <= 1'b0;
      dpath_sum_en          <= 1'b0;
      dpath_result_wraddr   <= '0;
      res_cnt               <= '0;
    end else begin
      dpath_wren   <= (state == STREAM);
      win_s1       <= (state == STREAM) && (w_cnt >= COL_W'(FILTER_L - 1));
      dpath_sum_en <= win_s1;
      if (state == STREAM) dpath_rotation_offset <= h0_mod;
      if (state == IDLE && start) begin
        res_cnt <= '0;
      end else if (win_s1) begin
        dpath_result_wraddr <= res_cnt;
        res_cnt             <= res_cnt + RRA'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_bram_sr_fast_ctrl.sv
// Testbench for conv_bram_sr_fast_ctrl: a 5x5 stride-1 instance and a
// 5x7 stride-2 instance share clock, reset, start and last_val.
module tb_conv_bram_sr_fast_ctrl;

  localparam int BA_A = $clog2(5 * ((5 + 3 - 1) / 3));
  localparam int BA_B = $clog2(5 * ((7 + 3 - 1) / 3));
  localparam int NRD  = 15;

  logic clk = 1'b0;
  logic reset, start, last_val;

  logic busy_a, done_a, wren_a, sum_a;
  logic [3*BA_A-1:0] addr_a;
  logic [1:0] off_a;
  logic [3:0] wr_a;
  logic busy_b, done_b, wren_b, sum_b;
  logic [3*BA_B-1:0] addr_b;
  logic [1:0] off_b;
  logic [3:0] wr_b;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  conv_bram_sr_fast_ctrl #(.IMG_W(5), .IMG_H(5), .FILTER_L(3), .STRIDE_H(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .busy(busy_a), .done(done_a),
    .img_rdaddr(addr_a), .dpath_wren(wren_a), .dpath_rotation_offset(off_a),
    .dpath_sum_en(sum_a), .dpath_result_wraddr(wr_a), .last_val(last_val));

  conv_bram_sr_fast_ctrl #(.IMG_W(5), .IMG_H(7), .FILTER_L(3), .STRIDE_H(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .busy(busy_b), .done(done_b),
    .img_rdaddr(addr_b), .dpath_wren(wren_b), .dpath_rotation_offset(off_b),
    .dpath_sum_en(sum_b), .dpath_result_wraddr(wr_b), .last_val(last_val));

  typedef struct {
    logic        start;
    logic        last_val;
    logic        busy;
    logic        done;
    logic        wren;
    logic        sum_en;
    int          wraddr;
    logic        chk_addr;
    logic [11:0] addr;
    int          off;
  } vec_t;

  vec_t tbl [28];

  // Drive one cycle of inputs just after the clock edge, then wait to the sampling edge.
  task automatic applyStimulus(input logic s, input logic lv, input logic rst);
    @(posedge clk);
    #1;
    start    = s;
    last_val = lv;
    reset    = rst;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Reference expectations computed straight from row/column arithmetic.
  task automatic check_dut(input string tag, input int w_img, input int l, input int s,
                           input int rh, input int ba, input int c, input int done_c,
                           input logic busy_v, input logic done_v, input logic [31:0] addr_v,
                           input logic wren_v, input logic [31:0] off_v, input logic sum_v,
                           input logic [31:0] wr_v);
    int n, rw, k, ho, w, h0, r, got;
    bit exp_wren, exp_sum;
    n  = w_img * rh;
    rw = w_img - l + 1;
    checkOutput({tag, "_busy"}, 32'(busy_v), 32'(c >= 1 && c <= done_c));
    checkOutput({tag, "_done"}, 32'(done_v), 32'(c == done_c));
    exp_wren = (c >= 2 && c <= n + 1);
    checkOutput({tag, "_wren"}, 32'(wren_v), 32'(exp_wren));
    k = c - 3;
    exp_sum = (k >= 0 && k < n && (k % w_img) >= l - 1);
    checkOutput({tag, "_sum_en"}, 32'(sum_v), 32'(exp_sum));
    if (exp_sum)
      checkOutput({tag, "_wraddr"}, wr_v, 32'((k % w_img) - l + 1 + (k / w_img) * rw));
    if (exp_wren) begin
      k = c - 2;
      checkOutput({tag, "_offset"}, off_v, 32'(((k / w_img) * s) % l));
    end
    if (c >= 1 && c <= n) begin
      k  = c - 1;
      ho = k / w_img;
      w  = k % w_img;
      h0 = ho * s;
      for (int b = 0; b < l; b++) begin
        r   = h0 + ((b - (h0 % l) + l) % l);
        got = int'((addr_v >> (b * ba)) & ((32'd1 << ba) - 1));
        checkOutput({tag, "_addr"}, 32'(got), 32'(w + (r / l) * w_img));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    checkOutput({tag, "_busy"},   32'(busy_a) | 32'(busy_b), 0);
    checkOutput({tag, "_done"},   32'(done_a) | 32'(done_b), 0);
    checkOutput({tag, "_wren"},   32'(wren_a) | 32'(wren_b), 0);
    checkOutput({tag, "_sum_en"}, 32'(sum_a)  | 32'(sum_b),  0);
    checkOutput({tag, "_addr"},   32'(addr_a) | 32'(addr_b), 0);
    checkOutput({tag, "_offset"}, 32'(off_a)  | 32'(off_b),  0);
    checkOutput({tag, "_wraddr"}, 32'(wr_a)   | 32'(wr_b),   0);
  endtask

  task automatic apply_table();
    for (int i = 0; i < 28; i++) begin
      applyStimulus(tbl[i].start, tbl[i].last_val, 1'b1);
      checkOutput("tbl_busy", 32'(busy_a), 32'(tbl[i].busy));
      checkOutput("tbl_done", 32'(done_a), 32'(tbl[i].done));
      checkOutput("tbl_wren", 32'(wren_a), 32'(tbl[i].wren));
      checkOutput("tbl_sum_en", 32'(sum_a), 32'(tbl[i].sum_en));
      if (tbl[i].sum_en) checkOutput("tbl_wraddr", 32'(wr_a), 32'(tbl[i].wraddr));
      if (tbl[i].wren) checkOutput("tbl_offset", 32'(off_a), 32'(tbl[i].off));
      if (tbl[i].chk_addr) checkOutput("tbl_addr", 32'(addr_a), 32'(tbl[i].addr));
      check_dut("B", 5, 3, 2, 3, BA_B, i, 26, busy_b, done_b, 32'(addr_b),
                wren_b, 32'(off_b), sum_b, 32'(wr_b));
    end
  endtask

  initial begin
    int lv_c, done_c, mode, cnt_a, cnt_b, last_wa, last_wb;
    bit hold;
    logic s, lv;

    // Cycle-by-cycle expectations for the 5x5 stride-1 run: start at 0, last_val at 25.
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0};
    tbl[1]  = '{0, 0, 1, 0, 0, 0, 0, 1, 12'h000, 0};
    tbl[2]  = '{0, 0, 1, 0, 1, 0, 0, 0, 12'h000, 0};
    tbl[3]  = '{0, 0, 1, 0, 1, 0, 0, 0, 12'h000, 0};
    tbl[4]  = '{1, 0, 1, 0, 1, 0, 0, 0, 12'h000, 0};
    tbl[5]  = '{0, 0, 1, 0, 1, 1, 0, 1, 12'h444, 0};
    tbl[6]  = '{0, 0, 1, 0, 1, 1, 1, 1, 12'h005, 0};
    tbl[7]  = '{0, 0, 1, 0, 1, 1, 2, 0, 12'h000, 1};
    tbl[8]  = '{0, 0, 1, 0, 1, 0, 0, 0, 12'h000, 1};
    tbl[9]  = '{0, 1, 1, 0, 1, 0, 0, 0, 12'h000, 1};
    tbl[10] = '{0, 0, 1, 0, 1, 1, 3, 1, 12'h449, 1};
    tbl[11] = '{0, 0, 1, 0, 1, 1, 4, 1, 12'h055, 1};
    tbl[12] = '{0, 0, 1, 0, 1, 1, 5, 0, 12'h000, 2};
    tbl[13] = '{0, 0, 1, 0, 1, 0, 0, 0, 12'h000, 2};
    tbl[14] = '{0, 0, 1, 0, 1, 0, 0, 0, 12'h000, 2};
    tbl[15] = '{0, 0, 1, 0, 1, 1, 6, 1, 12'h499, 2};
    tbl[16] = '{0, 0, 1, 0, 1, 1, 7, 0, 12'h000, 2};
    tbl[17] = '{0, 0, 1, 0, 0, 1, 8, 0, 12'h000, 0};
    for (int i = 18; i < 25; i++) tbl[i] = '{0, 0, 1, 0, 0, 0, 0, 0, 12'h000, 0};
    tbl[25] = '{0, 1, 1, 0, 0, 0, 0, 0, 12'h000, 0};
    tbl[26] = '{0, 0, 1, 1, 0, 0, 0, 0, 12'h000, 0};
    tbl[27] = '{0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0};

    reset = 1'b0;
    start = 1'b0;
    last_val = 1'b0;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    check_zero("reset");
    applyStimulus(0, 0, 1);

    $display("[TB] directed run");
    apply_table();
    applyStimulus(0, 0, 1);

    $display("[TB] reset during STREAM");
    applyStimulus(1, 0, 1);
    for (int c = 1; c < 8; c++) begin
      applyStimulus(0, 0, 1);
      check_dut("A", 5, 3, 1, 3, BA_A, c, 26, busy_a, done_a, 32'(addr_a),
                wren_a, 32'(off_a), sum_a, 32'(wr_a));
    end
    applyStimulus(0, 0, 0);
    check_zero("midreset");
    applyStimulus(0, 0, 1);
    check_zero("postreset");
    applyStimulus(0, 0, 1);
    apply_table();

    $display("[TB] randomized runs");
    for (int run = 0; run < 12; run++) begin
      mode = int'($urandom_range(0, 2));
      hold = ($urandom_range(0, 3) == 0);
      if (mode == 0) begin lv_c = NRD + 1; done_c = NRD + 4; end
      else if (mode == 1) begin lv_c = NRD + 2; done_c = NRD + 4; end
      else begin lv_c = NRD + 3 + int'($urandom_range(0, 8)); done_c = lv_c + 1; end
      cnt_a = 0; cnt_b = 0; last_wa = -1; last_wb = -1;
      for (int c = 0; c <= done_c + 2; c++) begin
        if (c == 0) s = 1'b1;
        else if (c > done_c) s = 1'b0;
        else s = hold ? 1'b1 : ($urandom_range(0, 4) == 0);
        if (c == lv_c) lv = 1'b1;
        else if (c <= NRD) lv = ($urandom_range(0, 5) == 0);
        else lv = 1'b0;
        applyStimulus(s, lv, 1'b1);
        check_dut("A", 5, 3, 1, 3, BA_A, c, done_c, busy_a, done_a, 32'(addr_a),
                  wren_a, 32'(off_a), sum_a, 32'(wr_a));
        check_dut("B", 5, 3, 2, 3, BA_B, c, done_c, busy_b, done_b, 32'(addr_b),
                  wren_b, 32'(off_b), sum_b, 32'(wr_b));
        if (sum_a) begin cnt_a++; last_wa = int'(wr_a); end
        if (sum_b) begin cnt_b++; last_wb = int'(wr_b); end
      end
      checkOutput("A_sum_count", 32'(cnt_a), 32'(3 * 3));
      checkOutput("B_sum_count", 32'(cnt_b), 32'(3 * 3));
      checkOutput("A_last_wraddr", 32'(last_wa), 32'(3 * 3 - 1));
      checkOutput("B_last_wraddr", 32'(last_wb), 32'(3 * 3 - 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_bram_sr_fast_ctrl.md
Name: conv_bram_sr_fast_ctrl

Overview:
- Control unit directly upstream of the fast shift-register conv datapath.
- Walks output rows and issues read addresses to the row-banked image BRAMs: FILTER_L banks per channel, image row r stored in bank r%FILTER_L at address w + (r/FILTER_L)*IMG_W, all channels sharing addresses.
- Drives the datapath's shift enable, rotation offset, window-valid and result write address.
- Runs the start/done handshake with the top level and terminates on the datapath's last_val.

Parameters:
- IMG_W, 16: image width.
- IMG_H, 16: image height.
- FILTER_L, 3: square filter length; also the number of row banks.
- STRIDE_H, 1: vertical stride. Horizontal stride is fixed at 1.
- RESULT_W, IMG_W-FILTER_L+1: derived, not set manually.
- RESULT_H, (IMG_H-FILTER_L)/STRIDE_H+1: derived.
- BANK_ADDR_WIDTH, $clog2(IMG_W*((IMG_H+FILTER_L-1)/FILTER_L)): per-bank address width.
- FILTER_L_ADDR_WIDTH, $clog2(FILTER_L): rotation offset width.
- RESULT_RAM_ADDR_WIDTH, $clog2(RESULT_W*RESULT_H): result address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  begin one convolution; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at completion.
- img_rdaddr  out  FILTER_L*BANK_ADDR_WIDTH  bank b address in slice b; BRAM read latency is 1 cycle.
- dpath_wren  out  1  shift one column into the datapath shift registers.
- dpath_rotation_offset  out  FILTER_L_ADDR_WIDTH  h0%FILTER_L, aligned with dpath_wren.
- dpath_sum_en  out  1  shift registers hold a complete window.
- dpath_result_wraddr  out  RESULT_RAM_ADDR_WIDTH  wo + ho*RESULT_W, valid with dpath_sum_en.
- last_val  in  1  datapath has written the final result.

Behaviour:
- Reset (async assert, sync release): state=IDLE. busy, done, dpath_wren and dpath_sum_en are 0. img_rdaddr, dpath_rotation_offset and dpath_result_wraddr are 0. All counters are 0.
- FSM states: IDLE, STREAM, FLUSH, WAIT_LAST, DONE.
  - IDLE→STREAM when start=1.
  - STREAM issues one read per cycle: column w=0..IMG_W-1 for output row ho=0..RESULT_H-1, back-to-back with no bubble between rows.
  - STREAM→FLUSH after the final read.
  - FLUSH lasts 2 cycles, draining the read pipeline and the final sum_en. FLUSH→WAIT_LAST.
  - WAIT_LAST→DONE on last_val=1. A last_val already seen during FLUSH is latched and honoured.
  - DONE asserts done for 1 cycle, then returns to IDLE.
- Bank address for read cycle (ho, w): h0=ho*STRIDE_H, r_b = h0 + ((b - h0%FILTER_L) mod FILTER_L), addr_b = w + (r_b/FILTER_L)*IMG_W.
  - Maintain these with incremental counters (h0 mod FILTER_L and a per-bank row base). No dividers.
- Pipeline: a read issued in cycle t produces dpath_wren in cycle t+1, with that row's rotation offset.
- Window valid: when the shift at cycle t+1 completes column w≥FILTER_L-1, dpath_sum_en=1 in cycle t+2 with wraddr=(w-FILTER_L+1)+ho*RESULT_W.
- Columns w<FILTER_L-1 of each row never raise sum_en; this refills the shift registers after a row change.
- dpath_result_wraddr increments by 1 per sum_en, reaches RESULT_W*RESULT_H-1, and never wraps within a run.
- start while busy is ignored. start in the same cycle as DONE is ignored; the next run starts only from IDLE.
- Reset mid-run immediately returns to IDLE with all outputs at their reset values. No done is produced.
- last_val outside FLUSH/WAIT_LAST is ignored.

Test Plan:
- IMG_W=IMG_H=5, FILTER_L=3, STRIDE_H=1; start at cycle 0 → reads in cycles 1..15; dpath_wren in cycles 2..16; sum_en in cycles 5–7, 10–12, 15–17 with wraddr 0..8 in order.
- Same config, bank addresses:
  - ho=0: all banks read w.
  - ho=1: bank0 reads w+5, banks1/2 read w, offset=1.
  - ho=2: banks0/1 read w+5, bank2 reads w, offset=2.
- last_val driven at cycle 25 → done=1 at cycle 26 only, busy=0 from cycle 27; last_val at cycle 17 (during FLUSH) → done at cycle 19.
- STRIDE_H=2, IMG_H=7, IMG_W=5, FILTER_L=3 → RESULT_H=3; h0=0,2,4 give offsets 0,2,1; 9 sum_en pulses, last wraddr=8.
- reset driven low at cycle 8 mid-STREAM → all outputs 0 in the same cycle; a fresh start afterwards reproduces the first scenario's timing exactly.
- start held high throughout a run → exactly one run. Second start pulse at cycle 4 → no effect.
